// File: rtl/conv_chan_sched.sv
// conv_chan_sched: drives one conv_3x3 across input channels and sums the
// per-channel partials into one 32-bit pre-activation per output pixel.
// Ports: start/cfg_* job setup, busy/done status, win_* window handshake,
// conv_*/wt_addr to the conv core and weight BRAM, conv_out/conv_data_valid
// back from the core, out_* valid/ready result stream.
module conv_chan_sched #(
  parameter int CIN_W     = 10,
  parameter int NPIX_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CIN_W-1:0]  cfg_cin,
  input  logic [NPIX_W-1:0] cfg_npix,
  input  logic [ADDR_W-1:0] cfg_wbase,
  input  logic [31:0]       cfg_bias,
  output logic              busy,
  output logic              done,
  input  logic              win_valid,
  output logic              win_ready,
  output logic              conv_valid_in,
  output logic [31:0]       conv_bias,
  output logic [ADDR_W-1:0] wt_addr,
  input  logic [31:0]       conv_out,
  input  logic              conv_data_valid,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int UW = PW + 1;
  localparam logic [UW-1:0] DEPTH = UW'(OUT_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              win_ready_q, win_ready_d;
  logic              conv_valid_q, conv_valid_d;
  logic [31:0]       conv_bias_q, conv_bias_d;
  logic [ADDR_W-1:0] wt_addr_q, wt_addr_d;
  logic [CIN_W-1:0]  cin_q, cin_d;
  logic [NPIX_W-1:0] npix_q, npix_d;
  logic [ADDR_W-1:0] wbase_q, wbase_d;
  logic [31:0]       bias_q, bias_d;
  logic [CIN_W-1:0]  ci_q, ci_d;
  logic [NPIX_W-1:0] pix_q, pix_d;
  logic [CIN_W-1:0]  rc_q, rc_d;
  logic [31:0]       acc_q, acc_d;
  logic [UW-1:0]     in_use_q, in_use_d;
  logic [UW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [31:0]       mem_q [OUT_DEPTH];
  logic [31:0]       mem_d [OUT_DEPTH];

  logic        accept, pop, push, res_v;
  logic        last_ci, last_pix, last_rc;
  logic [31:0] sum;

  always_comb begin
    accept   = win_valid & win_ready_q;
    pop      = (cnt_q != '0) & out_ready;
    last_ci  = ci_q == cin_q - CIN_W'(1);
    last_pix = pix_q == npix_q - NPIX_W'(1);
    last_rc  = rc_q == cin_q - CIN_W'(1);
    // results of an aborted job may still trickle in while idle
    res_v    = conv_data_valid &
               ((state_q == RUN) | (state_q == DRAIN));
    sum      = (rc_q == '0) ? conv_out : acc_q + conv_out;
    push     = res_v & last_rc;

    state_d      = state_q;
    cin_d        = cin_q;
    npix_d       = npix_q;
    wbase_d      = wbase_q;
    bias_d       = bias_q;
    ci_d         = ci_q;
    pix_d        = pix_q;
    rc_d         = rc_q;
    acc_d        = acc_q;
    conv_bias_d  = conv_bias_q;
    wt_addr_d    = wt_addr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_d        = mem_q;
    conv_valid_d = accept;

    if (accept) begin
      wt_addr_d   = wbase_q + ADDR_W'(ci_q);
      conv_bias_d = (ci_q == '0) ? bias_q : '0;
      ci_d        = last_ci ? '0 : ci_q + CIN_W'(1);
      if (last_ci) pix_d = pix_q + NPIX_W'(1);
    end

    if (res_v) begin
      acc_d = sum;
      rc_d  = last_rc ? '0 : rc_q + CIN_W'(1);
    end

    // a slot is reserved at a pixel's first window, freed on pop
    in_use_d = in_use_q + UW'(accept && (ci_q == '0)) - UW'(pop);
    cnt_d    = cnt_q + UW'(push) - UW'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = sum;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    unique case (state_q)
      IDLE: begin
        // busy_q still high during the done cycle
        if (start && !busy_q) begin
          cin_d   = cfg_cin;
          npix_d  = cfg_npix;
          wbase_d = cfg_wbase;
          bias_d  = cfg_bias;
          ci_d    = '0;
          pix_d   = '0;
          rc_d    = '0;
          acc_d   = '0;
          state_d = (cfg_cin == '0 || cfg_npix == '0) ? FIN : RUN;
        end
      end
      RUN:   if (accept && last_ci && last_pix) state_d = DRAIN;
      DRAIN: if (cnt_d == '0 && in_use_d == '0) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE) || (state_q == FIN);
    done_d      = state_q == FIN;
    win_ready_d = (state_d == RUN) &&
                  ((ci_d != '0) || (in_use_d < DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      win_ready_q  <= 1'b0;
      conv_valid_q <= 1'b0;
      conv_bias_q  <= '0;
      wt_addr_q    <= '0;
      cin_q        <= '0;
      npix_q       <= '0;
      wbase_q      <= '0;
      bias_q       <= '0;
      ci_q         <= '0;
      pix_q        <= '0;
      rc_q         <= '0;
      acc_q        <= '0;
      in_use_q     <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      win_ready_q  <= win_ready_d;
      conv_valid_q <= conv_valid_d;
      conv_bias_q  <= conv_bias_d;
      wt_addr_q    <= wt_addr_d;
      cin_q        <= cin_d;
      npix_q       <= npix_d;
      wbase_q      <= wbase_d;
      bias_q       <= bias_d;
      ci_q         <= ci_d;
      pix_q        <= pix_d;
      rc_q         <= rc_d;
      acc_q        <= acc_d;
      in_use_q     <= in_use_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_q        <= mem_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign win_ready     = win_ready_q;
  assign conv_valid_in = conv_valid_q;
  assign conv_bias     = conv_bias_q;
  assign wt_addr       = wt_addr_q;
  assign out_data      = mem_q[rd_ptr_q];
  assign out_valid     = cnt_q != '0;
endmodule

// File: tb/tb_conv_chan_sched.sv
// tb_conv_chan_sched: bench for conv_chan_sched with a behavioural
// conv_3x3 stand-in and a per-pixel sum reference.
module tb_conv_chan_sched;
  localparam int CIN_W     = 10;
  localparam int NPIX_W    = 16;
  localparam int ADDR_W    = 12;
  localparam int OUT_DEPTH = 4;
  localparam int AMOD      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [CIN_W-1:0]  cfg_cin;
  logic [NPIX_W-1:0] cfg_npix;
  logic [ADDR_W-1:0] cfg_wbase;
  logic [31:0]       cfg_bias;
  logic              busy, done;
  logic              win_valid, win_ready;
  logic              conv_valid_in;
  logic [31:0]       conv_bias;
  logic [ADDR_W-1:0] wt_addr;
  logic [31:0]       conv_out;
  logic              conv_data_valid;
  logic [31:0]       out_data;
  logic              out_valid, out_ready;

  always #5 clk = ~clk;

  conv_chan_sched #(
    .CIN_W(CIN_W), .NPIX_W(NPIX_W),
    .ADDR_W(ADDR_W), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_cin(cfg_cin), .cfg_npix(cfg_npix),
    .cfg_wbase(cfg_wbase), .cfg_bias(cfg_bias),
    .busy(busy), .done(done),
    .win_valid(win_valid), .win_ready(win_ready),
    .conv_valid_in(conv_valid_in), .conv_bias(conv_bias),
    .wt_addr(wt_addr), .conv_out(conv_out),
    .conv_data_valid(conv_data_valid),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  int wpix [4096];
  int wmem [AMOD*9];
  int cin_cur, npix_cur, wbase_cur, bias_cur;
  int acc_idx[$];
  int due_t[$];
  int due_v[$];
  int exp_q[$];
  int next_w, started, popped;
  int done_cnt, done_cyc, last_pop_cyc;
  bit busy_at_done;
  bit hold_f;
  logic [31:0] hold_v;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dot(input int w, input int a);
    int s = 0;
    for (int k = 0; k < 9; k++) s += wpix[w*9+k] * wmem[a*9+k];
    return s;
  endfunction

  // conv_3x3 stand-in: result returns 9 cycles after conv_valid_in
  initial begin
    conv_data_valid = 1'b0;
    conv_out = '0;
    forever begin
      @(posedge clk); #1;
      if (due_t.size() > 0 && due_t[0] <= cyc) begin
        conv_data_valid = 1'b1;
        conv_out = due_v.pop_front();
        void'(due_t.pop_front());
      end else begin
        conv_data_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int w, c, tot;
    tot = cin_cur * npix_cur;
    if (win_ready && cin_cur > 0) begin
      if (next_w % cin_cur == 0)
        chk("credit", 32'((started - popped) < OUT_DEPTH), 32'd1);
      chk("ready_range", 32'(next_w < tot), 32'd1);
    end
    if (win_valid && win_ready) begin
      acc_idx.push_back(next_w);
      if (cin_cur > 0 && next_w % cin_cur == 0) started++;
      next_w++;
    end
    if (conv_valid_in) begin
      if (acc_idx.size() == 0) begin
        chk("conv_orphan", 32'd1, 32'd0);
      end else begin
        w = acc_idx.pop_front();
        c = (cin_cur > 0) ? w % cin_cur : 0;
        chk("wt_addr", 32'(wt_addr), 32'((wbase_cur + c) % AMOD));
        chk("conv_bias", conv_bias, (c == 0) ? bias_cur : 0);
        due_t.push_back(cyc + 9);
        due_v.push_back($signed(conv_bias) + dot(w, int'(wt_addr)));
      end
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_out", 32'd1, 32'd0);
      else chk("out_data", out_data, exp_q.pop_front());
      popped++;
      last_pop_cyc = cyc;
    end
    if (hold_f && out_valid) chk("out_hold", out_data, hold_v);
    hold_f = out_valid && !out_ready;
    hold_v = out_data;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
  end

  task automatic setup(input int cin, input int npix, input int wb,
                       input int bias, input int pv, input int wv,
                       input bit rnd);
    int s;
    cin_cur = cin; npix_cur = npix;
    wbase_cur = wb; bias_cur = bias;
    next_w = 0; started = 0; popped = 0; done_cnt = 0;
    exp_q.delete();
    for (int i = 0; i < cin*npix*9; i++)
      wpix[i] = rnd ? $urandom_range(0, 15) - 8 : pv;
    for (int c = 0; c < cin; c++)
      for (int k = 0; k < 9; k++)
        wmem[((wb + c) % AMOD)*9+k] = rnd ? $urandom_range(0, 15) - 8 : wv;
    // expected pixel value straight from the definition
    for (int p = 0; p < npix; p++) begin
      s = bias;
      for (int c = 0; c < cin; c++)
        s += dot(p*cin + c, (wb + c) % AMOD);
      exp_q.push_back(s);
    end
  endtask

  task automatic drive_cfg();
    cfg_cin = CIN_W'(cin_cur);
    cfg_npix = NPIX_W'(npix_cur);
    cfg_wbase = ADDR_W'(wbase_cur);
    cfg_bias = bias_cur;
  endtask

  task automatic run_job(input int cin, input int npix, input int wb,
                         input int bias, input int pv, input int wv,
                         input bit rnd, input int vmode, input int rmode,
                         input int stall);
    int tot, gap, i;
    bit tog;
    setup(cin, npix, wb, bias, pv, wv, rnd);
    tot = cin * npix;
    tog = 1'b0;
    @(posedge clk); #1;
    drive_cfg();
    start = 1'b1;
    win_valid = 1'b0;
    for (i = 0; i < 3000 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      start = (i == 3);
      if (i == 3) begin
        cfg_cin = 10'd7; cfg_npix = 16'd9;
        cfg_wbase = '0; cfg_bias = 32'h123;
      end else begin
        drive_cfg();
      end
      tog = ~tog;
      win_valid = (next_w < tot) && (vmode == 0 ||
                  (vmode == 1 && tog) ||
                  (vmode == 2 && $urandom_range(0, 1) == 1));
      out_ready = (i < stall) ? 1'b0 :
                  (rmode == 0 || $urandom_range(0, 2) != 0);
      if (stall > 0 && i == stall) begin
        chk("stall_accepts", next_w,
            (tot < OUT_DEPTH*cin) ? tot : OUT_DEPTH*cin);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        if (tot > OUT_DEPTH*cin)
          chk("stall_win_ready", 32'(win_ready), 32'd0);
      end
    end
    win_valid = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", done_cnt, 1);
    chk("busy_at_done", 32'(busy_at_done), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("results_left", exp_q.size(), 0);
    chk("windows_taken", next_w, tot);
    gap = done_cyc - last_pop_cyc;
    chk("done_latency", 32'(gap >= 1 && gap <= 3), 32'd1);
    repeat (3) @(posedge clk);
    #1 chk("single_done", done_cnt, 1);
  endtask

  task automatic zero_job(input int cin, input int npix);
    setup(cin, npix, 0, 9, 1, 1, 1'b0);
    @(posedge clk); #1;
    drive_cfg();
    start = 1'b1;
    win_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      chk("zero_busy", 32'(busy), 32'(i < 2));
      chk("zero_done", 32'(done), 32'(i == 1));
      chk("zero_win_ready", 32'(win_ready), 32'd0);
      chk("zero_conv_valid", 32'(conv_valid_in), 32'd0);
    end
    win_valid = 1'b0;
    acc_idx.delete();
  endtask

  task automatic abort_then_job();
    int i;
    setup(3, 5, 32'h200, 2, 0, 0, 1'b1);
    @(posedge clk); #1;
    drive_cfg();
    start = 1'b1;
    for (i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      win_valid = 1'b1;
      out_ready = 1'b1;
    end
    rst_n = 1'b0;
    win_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc_idx.delete();
    exp_q.delete();
    next_w = 0; started = 0; popped = 0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_win_ready", 32'(win_ready), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    for (i = 0; i < 30 && due_t.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("stale_out_valid", 32'(out_valid), 32'd0);
    chk("stale_busy", 32'(busy), 32'd0);
    chk("abort_no_done", done_cnt, 0);
    run_job(3, 4, 32'h300, 11, 0, 0, 1'b1, 2, 1, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cfg_cin = '0; cfg_npix = '0; cfg_wbase = '0; cfg_bias = '0;
    win_valid = 1'b0;
    out_ready = 1'b1;
    cin_cur = 1; npix_cur = 0; wbase_cur = 0; bias_cur = 0;
    next_w = 0; started = 0; popped = 0; done_cnt = 0;
    hold_f = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_win_ready", 32'(win_ready), 32'd0);
    chk("rst_conv_valid", 32'(conv_valid_in), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_conv_bias", conv_bias, 32'd0);
    chk("rst_wt_addr", 32'(wt_addr), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;

    run_job(1, 3, 32'h010, 5, 1, 1, 1'b0, 0, 0, 0);
    run_job(4, 2, 32'h100, 5, 1, 1, 1'b0, 0, 0, 0);
    run_job(2, 8, 32'h040, 3, 1, 1, 1'b1, 0, 0, 80);
    zero_job(0, 5);
    zero_job(2, 0);
    run_job(3, 4, 32'h020, 7, 1, -1, 1'b0, 1, 0, 0);
    run_job(4, 3, 4094, -100, 0, 0, 1'b1, 2, 1, 0);
    for (int j = 0; j < 5; j++)
      run_job($urandom_range(1, 5), $urandom_range(1, 6),
              $urandom_range(0, AMOD-1), $urandom, 0, 0, 1'b1,
              2, 1, 0);
    abort_then_job();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
